// File: rtl/led_scanner_pkg.sv
// rtl/led_scanner_pkg.sv - shared types and constants for the LED pattern sequencer
package led_scanner_pkg;

    // Pattern modes as presented on the mode input
    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        ROT_R  = 2'd1,
        ROT_L  = 2'd2,
        FILL   = 2'd3
    } mode_e;

    // Sweep direction; in FILL it doubles as the phase (DIR_R filling, DIR_L draining)
    typedef enum logic {
        DIR_R = 1'b0,
        DIR_L = 1'b1
    } dir_e;

    // Width of the free-running PWM counter used when dimming is built in
    localparam int PWM_W = 4;

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - enable-gated step prescaler with synchronous clear
module led_prescaler
    import led_scanner_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    input  logic             clear,
    output logic             step
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // Comparing with >= makes a lowered period fire on the next enabled cycle
    // instead of waiting for the counter to wrap.
    assign step = en && !clear && (count_q >= period);

    // Next count: clear wins, a step restarts, enabled cycles count, otherwise hold
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (step) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + DIV_W'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_scanner.sv
// rtl/led_scanner.sv - parametrised LED pattern sequencer; optional dimming under LED_SCANNER_PWM_EN
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] period,
`ifdef LED_SCANNER_PWM_EN
    input  logic [4:0]       duty,
`endif
    output logic [WIDTH-1:0] leds,
    output logic             sweep_done
);

    localparam logic [WIDTH-1:0] PAT_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] PAT_MSB  = PAT_LSB << (WIDTH-1);
    localparam logic [WIDTH-1:0] PAT_B1   = PAT_LSB << 1;
    localparam logic [WIDTH-1:0] PAT_M2   = PAT_MSB >> 1;
    localparam logic [WIDTH-1:0] PAT_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] PAT_ZERO = {WIDTH{1'b0}};

    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             sweep_q, sweep_d;

    mode_e            mode_in;
    logic             mode_chg;
    logic             step;

    logic [WIDTH-1:0] nxt_pat;
    dir_e             nxt_dir;
    logic             legal;

    logic [WIDTH-1:0] pat_inv;
    logic [WIDTH-1:0] pat_inv_inc;
    logic [WIDTH-1:0] pat_inc;
    logic [WIDTH-1:0] pat_dec;

    // Pattern each mode starts from after reset, a mode switch or an illegal-state recovery
    function automatic logic [WIDTH-1:0] start_pat(input mode_e m);
        case (m)
            ROT_L:   start_pat = PAT_LSB;
            FILL:    start_pat = PAT_ZERO;
            default: start_pat = PAT_MSB;
        endcase
    endfunction

    // Patterns that mark the end of a sweep in each mode
    function automatic logic is_terminal(input mode_e m, input logic [WIDTH-1:0] p);
        case (m)
            BOUNCE:  is_terminal = (p == PAT_LSB) || (p == PAT_MSB);
            ROT_R:   is_terminal = (p == PAT_LSB);
            ROT_L:   is_terminal = (p == PAT_MSB);
            default: is_terminal = (p == PAT_ONES) || (p == PAT_ZERO);
        endcase
    endfunction

    assign mode_in  = mode_e'(mode);
    assign mode_chg = (mode_in != mode_q);

    // Helpers for shape tests: x & (x+1) == 0 means x is ones anchored at the LSB
    assign pat_inv     = ~pat_q;
    assign pat_inv_inc = pat_inv + WIDTH'(1);
    assign pat_inc     = pat_q + WIDTH'(1);
    assign pat_dec     = pat_q - WIDTH'(1);

    // A pending mode switch clears the prescaler so the new mode starts a full period
    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .period (period),
        .clear  (mode_chg),
        .step   (step)
    );

    // Candidate next pattern and direction for the current mode, plus shape legality
    always_comb begin
        nxt_pat = pat_q;
        nxt_dir = dir_q;
        legal   = 1'b1;
        case (mode_q)
            BOUNCE: begin
                legal = (pat_q != PAT_ZERO) && ((pat_q & pat_dec) == PAT_ZERO);
                if (dir_q == DIR_R) begin
                    if (pat_q[0]) begin
                        nxt_pat = PAT_B1;
                        nxt_dir = DIR_L;
                    end else begin
                        nxt_pat = pat_q >> 1;
                    end
                end else begin
                    if (pat_q[WIDTH-1]) begin
                        nxt_pat = PAT_M2;
                        nxt_dir = DIR_R;
                    end else begin
                        nxt_pat = pat_q << 1;
                    end
                end
            end
            ROT_R: begin
                legal   = (pat_q != PAT_ZERO) && ((pat_q & pat_dec) == PAT_ZERO);
                nxt_pat = {pat_q[0], pat_q[WIDTH-1:1]};
            end
            ROT_L: begin
                legal   = (pat_q != PAT_ZERO) && ((pat_q & pat_dec) == PAT_ZERO);
                nxt_pat = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
            end
            default: begin
                if (dir_q == DIR_R) begin
                    // Filling: ones grow down from the MSB and must not already be full
                    legal   = ((pat_inv & pat_inv_inc) == PAT_ZERO) && (pat_q != PAT_ONES);
                    nxt_pat = {1'b1, pat_q[WIDTH-1:1]};
                    if (nxt_pat == PAT_ONES) begin
                        nxt_dir = DIR_L;
                    end
                end else begin
                    // Draining: remaining ones sit at the LSB end and must not be empty
                    legal   = ((pat_q & pat_inc) == PAT_ZERO) && (pat_q != PAT_ZERO);
                    nxt_pat = {1'b0, pat_q[WIDTH-1:1]};
                    if (nxt_pat == PAT_ZERO) begin
                        nxt_dir = DIR_R;
                    end
                end
            end
        endcase
    end

    // State update: mode change over step over hold; sweep pulse only on real steps
    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        pat_d   = pat_q;
        sweep_d = 1'b0;
        if (mode_chg) begin
            mode_d = mode_in;
            pat_d  = start_pat(mode_in);
            dir_d  = DIR_R;
        end else if (step) begin
            if (legal) begin
                pat_d   = nxt_pat;
                dir_d   = nxt_dir;
                sweep_d = is_terminal(mode_q, nxt_pat);
            end else begin
                pat_d = start_pat(mode_q);
                dir_d = DIR_R;
            end
        end
    end

    // Pattern, direction, mode and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= BOUNCE;
            dir_q   <= DIR_R;
            pat_q   <= PAT_MSB;
            sweep_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            pat_q   <= pat_d;
            sweep_q <= sweep_d;
        end
    end

    assign sweep_done = sweep_q;

`ifdef LED_SCANNER_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             pwm_on;

    // Free-running dimming counter
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    end

    // Dimming counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // duty is one bit wider than the counter so 16 and above keep the LEDs fully on
    assign pwm_on = ({1'b0, pwm_cnt_q} < duty);
    assign leds   = pat_q & {WIDTH{pwm_on}};
`else
    assign leds = pat_q;
`endif

endmodule

// File: tb/tb_led_scanner.sv
// tb/tb_led_scanner.sv - self-checking bench for led_scanner with WIDTH=4
module tb_led_scanner;

    localparam int W     = 4;
    localparam int DIV_W = 24;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] period;
    logic [W-1:0]     leds;
    logic             sweep_done;
`ifdef LED_SCANNER_PWM_EN
    logic [4:0]       duty;
`endif

    int checks;
    int errors;

    led_scanner #(
        .WIDTH (W),
        .DIV_W (DIV_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .period     (period),
`ifdef LED_SCANNER_PWM_EN
        .duty       (duty),
`endif
        .leds       (leds),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: position index within each mode's cyclic sequence of patterns
    int   p_m;
    int   cnt_m;
    int   mode_m;
    logic sw_m;
    bit   model_ok;

    function automatic int mlen(input int m);
        case (m)
            0:       mlen = 2 * W - 2;
            1, 2:    mlen = W;
            default: mlen = 2 * W;
        endcase
    endfunction

    function automatic logic [W-1:0] mpat(input int m, input int p);
        int v;
        case (m)
            0:       v = (p < W) ? (1 << (W - 1 - p)) : (1 << (p - W + 1));
            1:       v = 1 << (W - 1 - p);
            2:       v = 1 << p;
            default: v = (p <= W) ? (((1 << p) - 1) << (W - p)) : ((1 << (2 * W - p)) - 1);
        endcase
        mpat = W'(v);
    endfunction

    function automatic logic mterm(input int m, input int p);
        case (m)
            0:       mterm = (p == 0) || (p == W - 1);
            1, 2:    mterm = (p == W - 1);
            default: mterm = (p == 0) || (p == W);
        endcase
    endfunction

    // Model update on each rising edge from the inputs the DUT sees
    always @(posedge clk) begin
        if (rst) begin
            p_m      <= 0;
            mode_m   <= 0;
            cnt_m    <= 0;
            sw_m     <= 1'b0;
            model_ok <= 1'b1;
        end else if (int'(mode) != mode_m) begin
            p_m    <= 0;
            mode_m <= int'(mode);
            cnt_m  <= 0;
            sw_m   <= 1'b0;
        end else if (en && (cnt_m >= int'(period))) begin
            p_m   <= (p_m + 1) % mlen(mode_m);
            sw_m  <= mterm(mode_m, (p_m + 1) % mlen(mode_m));
            cnt_m <= 0;
        end else begin
            sw_m <= 1'b0;
            if (en) cnt_m <= cnt_m + 1;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (leds !== mpat(mode_m, p_m) || sweep_done !== sw_m) begin
                errors++;
                $display("FAIL model t=%0t leds=%b sweep=%b expected leds=%b sweep=%b",
                         $time, leds, sweep_done, mpat(mode_m, p_m), sw_m);
            end
        end
    end

    // Hand-computed literal expectation at the next falling edge
    task automatic tick_chk(input string nm, input logic [W-1:0] e, input logic s);
        @(negedge clk);
        checks++;
        if (leds !== e || sweep_done !== s) begin
            errors++;
            $display("FAIL %s leds=%b sweep=%b expected leds=%b sweep=%b", nm, leds, sweep_done, e, s);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        model_ok = 1'b0;
        rst      = 1'b1;
        en       = 1'b1;
        mode     = 2'd0;
        period   = '0;
`ifdef LED_SCANNER_PWM_EN
        duty     = 5'd16;
`endif
        @(negedge clk);
        tick_chk("reset", 4'b1000, 1'b0);
        rst = 1'b0;

        tick_chk("bounce1", 4'b0100, 1'b0);
        tick_chk("bounce2", 4'b0010, 1'b0);
        tick_chk("bounce3", 4'b0001, 1'b1);
        tick_chk("bounce4", 4'b0010, 1'b0);
        tick_chk("bounce5", 4'b0100, 1'b0);
        tick_chk("bounce6", 4'b1000, 1'b1);
        tick_chk("bounce7", 4'b0100, 1'b0);
        tick_chk("bounce8", 4'b0010, 1'b0);
        tick_chk("bounce9", 4'b0001, 1'b1);
        tick_chk("bounce10", 4'b0010, 1'b0);
        rst = 1'b1;
        tick_chk("midrst", 4'b1000, 1'b0);
        rst = 1'b0;
        tick_chk("postrst", 4'b0100, 1'b0);

        mode = 2'd1;
        tick_chk("rotr_reload", 4'b1000, 1'b0);
        tick_chk("rotr1", 4'b0100, 1'b0);
        tick_chk("rotr2", 4'b0010, 1'b0);
        tick_chk("rotr3", 4'b0001, 1'b1);
        tick_chk("rotr4", 4'b1000, 1'b0);
        mode = 2'd2;
        tick_chk("rotl_reload", 4'b0001, 1'b0);
        tick_chk("rotl1", 4'b0010, 1'b0);
        tick_chk("rotl2", 4'b0100, 1'b0);
        tick_chk("rotl3", 4'b1000, 1'b1);
        tick_chk("rotl4", 4'b0001, 1'b0);

        mode = 2'd3;
        tick_chk("fill_reload", 4'b0000, 1'b0);
        tick_chk("fill1", 4'b1000, 1'b0);
        tick_chk("fill2", 4'b1100, 1'b0);
        tick_chk("fill3", 4'b1110, 1'b0);
        tick_chk("fill4", 4'b1111, 1'b1);
        tick_chk("fill5", 4'b0111, 1'b0);
        tick_chk("fill6", 4'b0011, 1'b0);
        tick_chk("fill7", 4'b0001, 1'b0);
        tick_chk("fill8", 4'b0000, 1'b1);
        tick_chk("fill9", 4'b1000, 1'b0);

        mode   = 2'd0;
        period = 24'd2;
        tick_chk("p2_reload", 4'b1000, 1'b0);
        tick_chk("p2_a", 4'b1000, 1'b0);
        tick_chk("p2_b", 4'b1000, 1'b0);
        tick_chk("p2_c", 4'b0100, 1'b0);
        tick_chk("p2_d", 4'b0100, 1'b0);
        tick_chk("p2_e", 4'b0100, 1'b0);
        tick_chk("p2_f", 4'b0010, 1'b0);
        tick_chk("p2_g", 4'b0010, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick_chk("hold", 4'b0010, 1'b0);
        en = 1'b1;
        tick_chk("resume1", 4'b0010, 1'b0);
        tick_chk("resume2", 4'b0001, 1'b1);

        period = 24'd9;
        for (int i = 0; i < 5; i++) tick_chk("p9_count", 4'b0001, 1'b0);
        period = 24'd1;
        tick_chk("p_drop", 4'b0010, 1'b0);
        tick_chk("p1_a", 4'b0010, 1'b0);
        tick_chk("p1_b", 4'b0100, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_scanner.md
Name: led_scanner

Overview:
Parametrised LED pattern sequencer, the successor to the fixed 18-LED bounce scanner. Adds configurable width, a programmable step prescaler, four pattern modes, enable/hold, and an end-of-sweep pulse. Unlike its predecessor, it has no dead cycle at endpoints. Sits between the board clock and the LED bank; mode and period come from switches or a control register.

Parameters:
WIDTH, 18, number of LEDs; must be at least 2.
DIV_W, 24, width of the prescaler counter and of the period input.

Ports:
clk  input  1  single system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
en  input  1  1 = sequencing runs; 0 = prescaler and pattern hold.
mode  input  2  0 BOUNCE, 1 ROT_R, 2 ROT_L, 3 FILL.
period  input  DIV_W  step every period+1 enabled cycles.
leds  output  WIDTH  registered LED pattern.
sweep_done  output  1  registered one-cycle pulse when leds reaches a terminal pattern.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - leds = MSB one-hot (1 << WIDTH-1).
  - dir = right (towards LSB); mode_r = BOUNCE.
  - count = 0; sweep_done = 0.
- Prescaler:
  - step = en && (count >= period).
  - On step, count <= 0; else if en, count <= count+1; else count holds.
  - period=0 gives a step every cycle.
  - If period is lowered below count, a step fires on the next enabled cycle.
- leds update on the edge where step=1 (one-cycle latency from the step condition). leds hold otherwise.
- BOUNCE:
  - A single lit bit, initially shifting right.
  - At LSB moving right: next = bit1, dir <= left.
  - At MSB moving left: next = bit WIDTH-2, dir <= right.
  - No repeated or blank pattern at the turn.
- ROT_R: rotate right; LSB wraps to MSB.
- ROT_L: rotate left; MSB wraps to LSB.
- FILL:
  - Shift right inserting 1 at MSB until all-ones.
  - Then shift right inserting 0 until all-zeros, then repeat (fill phase tracked by dir).
- Illegal pattern in the current mode (e.g. non-one-hot in BOUNCE/ROT after a mode-change race): reload the start pattern on the next step.
- Mode change:
  - When mode != mode_r, on the next clock (independent of en/step): mode_r <= mode, leds <= start pattern, dir <= right, count <= 0.
  - Start patterns: BOUNCE MSB, ROT_R MSB, ROT_L LSB, FILL zeros.
  - No step is taken on that cycle.
- sweep_done:
  - Set on the same edge where a step loads a terminal pattern, so it is high while leds shows it; cleared next cycle.
  - Terminal patterns: BOUNCE LSB or MSB; ROT_R LSB; ROT_L MSB; FILL all-ones or all-zeros.
  - Mode-change reloads and reset never raise it.
- Precedence: rst > mode change > step > hold.
- Reset mid-sweep restores the reset values on the next edge regardless of en.

Optional Feature:
LED_SCANNER_PWM_EN:
- Defined:
  - Adds input duty[4:0] and a free-running 4-bit pwm_cnt (reset 0).
  - leds output = pattern & {WIDTH{pwm_cnt < duty}}.
  - duty=0 is dark; duty>=16 is full on.
  - Pattern state and sweep_done are unaffected by PWM.
- Undefined: no duty port and no pwm_cnt; leds = pattern register directly.

Decomposition:
- Package led_scanner_pkg: mode_e enum (BOUNCE, ROT_R, ROT_L, FILL), dir_e (DIR_R, DIR_L), PWM_W=4.
- One sub-module: led_prescaler (en, period, clear → step), reused elsewhere for blink timing.

Test Plan:
- WIDTH=4, period=0, en=1, BOUNCE from reset → leds 1000, 0100, 0010, 0001, 0010, 0100, 1000, 0100 on successive cycles; sweep_done high with 0001 and with 1000 only.
- ROT_R then ROT_L, WIDTH=4 → 1000→0100→0010→0001→1000; after the switch, reload to 0001 then 0010, 0100; sweep_done on 0001 (ROT_R) and 1000 (ROT_L); no pulse on reload.
- FILL, WIDTH=4 → 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; sweep_done at 1111 and 0000 (not at the reload 0000).
- period=2 → leds change every 3rd cycle. en=0 for 5 cycles mid-sweep → leds and count frozen, then resume with the same remaining count. period dropped 9→1 with count=5 → step on the next cycle.
- rst pulsed mid-BOUNCE while moving left at 0010 → next edge leds=1000, dir right, sweep_done=0; the following step gives 0100.
- PWM build, duty=4 → each lit bit high 4 of every 16 cycles; duty=0 → leds all 0 while the pattern advances; duty=16 → equals the non-PWM build.
